wt_dcache_shct: RTL
===================

Name: wt_dcache_shct

Overview:
Parametrised Signature History Counter Table (SHCT) for the write-through L1 dcache's SHiP-style replacement predictor. It holds 2^SigWidth saturating counters. The table is trained by hit and eviction events and answers registered lookups with a counter value plus a distant-reuse flag. Reset and flush clear the table with an in-place sweep FSM, so the storage can map to SRAM/flop arrays without a global parallel reset.

Parameters:
SigWidth, 14, signature/index width; table depth = 2**SigWidth
CntWidth, 2, counter width in bits (1..4)
CntInit, 2**CntWidth-1, value written to every entry by the init sweep
DistantThr, 0, lookup_distant_o asserted when counter <= DistantThr

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
flush_i  in  1  pulse: re-initialise the whole table
init_done_o  out  1  high when the table is usable (RUN state)
lookup_req_i  in  1  lookup request (miss fill, predict insertion)
lookup_sig_i  in  SigWidth  lookup signature
lookup_gnt_o  out  1  lookup accepted this cycle
lookup_vld_o  out  1  result valid (one cycle after grant)
lookup_cnt_o  out  CntWidth  counter value for granted lookup
lookup_distant_o  out  1  counter <= DistantThr (insert at distant RRPV)
hit_upd_i  in  1  line hit: increment counter at hit_sig_i
hit_sig_i  in  SigWidth  signature stored in hit line
evict_upd_i  in  1  line evicted
evict_reused_i  in  1  evicted line had been re-referenced
evict_sig_i  in  SigWidth  signature of evicted line

Behaviour:
- States: INIT, RUN. rst_i (sync, active-high) forces INIT with sweep index 0. Reset output values: init_done_o=0, lookup_gnt_o=0, lookup_vld_o=0, lookup_cnt_o=0, lookup_distant_o=0.
- INIT: each cycle writes CntInit to entry[idx], then idx++. After the write to entry 2**SigWidth-1, the FSM enters RUN. The sweep takes exactly 2**SigWidth cycles.
- INIT: lookup_gnt_o=0. hit/evict updates are dropped, not queued.
- flush_i in RUN: next state INIT with idx=0. flush_i during INIT: idx restarts at 0. rst_i has priority over flush_i.
- RUN: lookup_gnt_o = lookup_req_i. There is no backpressure outside INIT.
- Lookup latency is 1 cycle. lookup_vld_o pulses exactly one cycle after a grant. lookup_cnt_o and lookup_distant_o hold their last value when vld is low.
- Write-first rule: a lookup granted in cycle N returns the entry value after all updates applied in cycle N.
- Hit update: counter+1, saturating at 2**CntWidth-1.
- Evict update with evict_reused_i=0: counter-1, saturating at 0. With evict_reused_i=1: no change.
- hit and evict (non-reused) to the same signature in the same cycle: net unchanged. Different signatures: both applied.
- All arithmetic is done in CntWidth+1 bits, then clamped. No wrap-around is ever visible.
- A flush in cycle N takes effect in cycle N+1. A lookup granted in cycle N still returns its pre-flush value in N+1.

Decomposition:
- Add to wt_cache_pkg: ShipSigWidth=14, ShipCntWidth=2, typedef shct_sig_t, typedef shct_cnt_t, typedef shct_state_e {SHCT_INIT, SHCT_RUN}.
- Sub-module wt_dcache_shct_ctr: combinational saturating update of one counter. Inputs: old value, inc, dec. Output: new value. Parametrised on CntWidth.
- The table array and the sweep FSM stay in the top module.

Test Plan (bench config SigWidth=4, CntWidth=2, CntInit=3, DistantThr=0):
- Reset 1 cycle, hold lookup_req_i=1 -> gnt=0 for 16 cycles; init_done_o rises on cycle 17; the first lookup of sig 5 returns cnt=3, distant=0.
- 4 evict_upd (reused=0) on sig 7, then lookup 7 -> cnt=0, distant=1. A 5th evict leaves cnt=0 (no underflow).
- From 0: 5 hit_upd on sig 7 -> cnt=3 (saturates at 3). hit+evict on sig 7 in the same cycle -> cnt unchanged.
- Same cycle: lookup sig 2 (value 1) with hit_upd sig 2 -> lookup_vld_o next cycle with cnt=2 (write-first).
- Decrement sig 9 to 0, pulse flush_i mid-run -> init_done_o=0 for 16 cycles; lookup 9 afterwards -> 3. A second flush at sweep idx 8 restarts the sweep: 16 more cycles.
- evict_reused_i=1 on sig 4 -> value unchanged. rst_i asserted mid-sweep -> sweep restarts from idx 0; the lookup result from that cycle is not presented (vld=0).

Source files
------------

// File: rtl/wt_cache_pkg.sv
// Shared types and defaults for the write-through cache, including the
// SHiP signature history counter table used by the dcache replacement predictor.
package wt_cache_pkg;

    localparam int unsigned ShipSigWidth = 14;
    localparam int unsigned ShipCntWidth = 2;

    typedef logic [ShipSigWidth-1:0] shct_sig_t;
    typedef logic [ShipCntWidth-1:0] shct_cnt_t;

    typedef enum logic {
        SHCT_INIT,
        SHCT_RUN
    } shct_state_e;

endpackage

// File: rtl/wt_dcache_shct_ctr.sv
// Combinational saturating update of one SHCT counter: +1 on inc, -1 on dec,
// unchanged when both or neither are set; never wraps.
module wt_dcache_shct_ctr #(
    parameter int unsigned CntWidth = 2
) (
    input  logic [CntWidth-1:0] old_cnt,
    input  logic                inc,
    input  logic                dec,
    output logic [CntWidth-1:0] new_cnt
);

    localparam logic [CntWidth:0] CntMax = {1'b0, {CntWidth{1'b1}}};
    localparam logic [CntWidth:0] One    = {{CntWidth{1'b0}}, 1'b1};

    logic [CntWidth:0] ext;
    logic [CntWidth:0] sum;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        ext = {1'b0, old_cnt};
        sum = ext;
        if (inc && !dec) begin
            sum = ext + One;
        end else if (dec && !inc) begin
            sum = (ext == '0) ? '0 : ext - One;
        end
        new_cnt = (sum > CntMax) ? CntMax[CntWidth-1:0] : sum[CntWidth-1:0];
    end

endmodule

// File: rtl/wt_dcache_shct.sv
// Signature History Counter Table: trained by hit/evict events, answers
// registered write-first lookups, and re-initialises itself with a sweep FSM.
module wt_dcache_shct
    import wt_cache_pkg::*;
#(
    parameter int unsigned SigWidth   = ShipSigWidth,
    parameter int unsigned CntWidth   = ShipCntWidth,
    parameter int unsigned CntInit    = 2**CntWidth-1,
    parameter int unsigned DistantThr = 0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    output logic                init_done_o,
    input  logic                lookup_req_i,
    input  logic [SigWidth-1:0] lookup_sig_i,
    output logic                lookup_gnt_o,
    output logic                lookup_vld_o,
    output logic [CntWidth-1:0] lookup_cnt_o,
    output logic                lookup_distant_o,
    input  logic                hit_upd_i,
    input  logic [SigWidth-1:0] hit_sig_i,
    input  logic                evict_upd_i,
    input  logic                evict_reused_i,
    input  logic [SigWidth-1:0] evict_sig_i
);

    localparam int unsigned Depth = 2**SigWidth;

    typedef logic [CntWidth-1:0] cnt_t;

    cnt_t                mem [Depth];
    shct_state_e         state_q;
    logic [SigWidth-1:0] idx_q;

    logic run;
    logic hit_en;
    logic evict_en;
    logic same_sig;
    cnt_t hit_new;
    cnt_t evict_new;
    cnt_t lookup_new;

    assign run          = (state_q == SHCT_RUN);
    assign init_done_o  = run;
    assign lookup_gnt_o = run & lookup_req_i;
    assign hit_en       = run & hit_upd_i;
    assign evict_en     = run & evict_upd_i & ~evict_reused_i;
    assign same_sig     = (hit_sig_i == evict_sig_i);

    // A hit and a decrement on the same signature cancel inside each updater.
    wt_dcache_shct_ctr #(.CntWidth(CntWidth)) u_hit_ctr (
        .old_cnt (mem[hit_sig_i]),
        .inc     (1'b1),
        .dec     (evict_en & same_sig),
        .new_cnt (hit_new)
    );

    wt_dcache_shct_ctr #(.CntWidth(CntWidth)) u_evict_ctr (
        .old_cnt (mem[evict_sig_i]),
        .inc     (hit_en & same_sig),
        .dec     (1'b1),
        .new_cnt (evict_new)
    );

    // Lookup sees this cycle's updates, giving write-first read semantics.
    wt_dcache_shct_ctr #(.CntWidth(CntWidth)) u_lookup_ctr (
        .old_cnt (mem[lookup_sig_i]),
        .inc     (hit_en & (hit_sig_i == lookup_sig_i)),
        .dec     (evict_en & (evict_sig_i == lookup_sig_i)),
        .new_cnt (lookup_new)
    );

    // NOTE: the array has no reset; the INIT sweep clears it so it can map to SRAM.
    always_ff @(posedge clk_i) begin
        if (state_q == SHCT_INIT) begin
            mem[idx_q] <= cnt_t'(CntInit);
        end else begin
            if (hit_en)   mem[hit_sig_i]   <= hit_new;
            if (evict_en) mem[evict_sig_i] <= evict_new;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q          <= SHCT_INIT;
            idx_q            <= '0;
            lookup_vld_o     <= 1'b0;
            lookup_cnt_o     <= '0;
            lookup_distant_o <= 1'b0;
        end else begin
            lookup_vld_o <= lookup_gnt_o;
            if (lookup_gnt_o) begin
                lookup_cnt_o     <= lookup_new;
                lookup_distant_o <= (lookup_new <= cnt_t'(DistantThr));
            end
            case (state_q)
                SHCT_INIT: begin
                    if (flush_i) begin
                        idx_q <= '0;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                        if (idx_q == '1) state_q <= SHCT_RUN;
                    end
                end
                SHCT_RUN: begin
                    if (flush_i) begin
                        state_q <= SHCT_INIT;
                        idx_q   <= '0;
                    end
                end
                default: state_q <= SHCT_INIT;
            endcase
        end
    end

endmodule
